fft_pair_feeder: RTL and testbench

- Upstream stage of the fft multiplier datapath.
- Collects a serial stream of 8-bit samples into N-sample frames using two ping-pong buffer banks.
- Replays each complete frame as N/2 butterfly operand pairs (x[k], x[k+N/2]), which drive the multiplier's data1/data2 inputs.
- Both sides use a valid/ready handshake, so stalls propagate cleanly.

---
 rtl/fft_pair_feeder.sv | 174 +++++++++++++++++
 tb/tb_fft_pair_feeder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_pair_feeder
// Purpose  : Upstream stage of the fft multiplier datapath. Collects a serial
//            stream of samples into N-sample frames using two ping-pong
//            banks, then replays each complete frame as N/2 butterfly operand
//            pairs (x[k], x[k+N/2]) for the multiplier's data1/data2 inputs.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_valid  - in_data carries a sample this cycle
//            in_data   - input sample (DW bits)
//            in_ready  - block can accept a sample this cycle (registered)
//            out_valid - out_a/out_b/out_idx/out_last hold a valid pair
//            out_ready - downstream takes the pair this cycle
//            out_a     - x[k], feeds multiplier data1
//            out_b     - x[k+N/2], feeds multiplier data2
//            out_idx   - pair index k, 0..N/2-1
//            out_last  - high with the final pair of a frame
// Revision : 1.0 - initial release
// ============================================================================
module fft_pair_feeder #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-2:0] out_idx,
  output logic          out_last
);

  localparam int            HALF    = N / 2;
  localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
  localparam logic [AW-2:0] RD_LAST = (AW - 1)'(HALF - 1);

  if (N < 4 || (1 << AW) != N) begin : g_param_check
    $error("fft_pair_feeder: N must be a power of 2 >= 4 and equal 2**AW");
  end

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Both banks live in one array; the bank select is the address MSB.
  logic [DW-1:0] mem [2*N];

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic [1:0]    bank_full;
  logic          rd_bank;
  logic [AW-2:0] rd_cnt;
  state_t        state;

  logic          accept;
  logic          frame_done;
  logic          pair_take;
  logic          release_bank;
  logic [1:0]    full_nxt;
  logic          wr_bank_nxt;

  // Address of x[k] (upper=0) or x[k+N/2] (upper=1) within a bank.
  function automatic logic [AW:0] pair_addr(input logic bank, input logic upper,
                                            input logic [AW-2:0] k);
    return {bank, upper, k};
  endfunction

  assign accept       = in_valid && in_ready;
  assign frame_done   = accept && (wr_cnt == WR_LAST);
  assign pair_take    = out_valid && out_ready;
  assign release_bank = (state == S_STREAM) && pair_take && out_last;
  assign wr_bank_nxt  = wr_bank ^ frame_done;

  // A frame may complete in the same cycle the other bank is released; both
  // flag updates apply. They never target the same bank because the write
  // bank's flag is clear whenever samples are being accepted into it.
  always_comb begin
    full_nxt = bank_full;
    if (frame_done)   full_nxt[wr_bank] = 1'b1;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
  end

  // Sample storage: contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wr_bank, wr_cnt}] <= in_data;
    end
  end

  // Write side. in_ready is computed from next-state values so that it is a
  // pure register yet still reopens the cycle after a bank is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= 2'b00;
      in_ready  <= 1'b1;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;  // wraps to 0 on the Nth sample
      end
      wr_bank   <= wr_bank_nxt;
      bank_full <= full_nxt;
      in_ready  <= !full_nxt[wr_bank_nxt];
    end
  end

  // Read side FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bank_full[rd_bank]) begin
            out_a     <= mem[pair_addr(rd_bank, 1'b0, '0)];
            out_b     <= mem[pair_addr(rd_bank, 1'b1, '0)];
            out_idx   <= '0;
            out_last  <= (HALF == 1);
            out_valid <= 1'b1;
            rd_cnt    <= (AW - 1)'(1);
            state     <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (pair_take) begin
            if (out_last) begin
              rd_bank <= ~rd_bank;
              // Zero-bubble chaining when the other bank is already waiting.
              if (bank_full[~rd_bank]) begin
                out_a    <= mem[pair_addr(~rd_bank, 1'b0, '0)];
                out_b    <= mem[pair_addr(~rd_bank, 1'b1, '0)];
                out_idx  <= '0;
                out_last <= (HALF == 1);
                rd_cnt   <= (AW - 1)'(1);
              end else begin
                out_valid <= 1'b0;
                state     <= S_IDLE;
              end
            end else begin
              out_a    <= mem[pair_addr(rd_bank, 1'b0, rd_cnt)];
              out_b    <= mem[pair_addr(rd_bank, 1'b1, rd_cnt)];
              out_idx  <= rd_cnt;
              out_last <= (rd_cnt == RD_LAST);
              rd_cnt   <= rd_cnt + 1'b1;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_pair_feeder
// Purpose  : Self-checking bench for fft_pair_feeder. A frame-level reference
//            model collects accepted samples and, per completed frame, queues
//            the expected (x[k], x[k+N/2]) pairs; an independent monitor pops
//            and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_pair_feeder;

  localparam int N    = 16;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int HALF = N / 2;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-2:0] idx;
    logic          last;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [AW-2:0] out_idx;
  logic          out_last;

  fft_pair_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] frame_q[$];
  pair_t         exp_q[$];
  int            hs_cyc[$];
  int            acc_count = 0;
  int            last_accept_cyc = -1;
  int            first_valid_cyc = -1;
  bit            check_ready_high = 0;
  bit            drv_done = 1;
  bit            held_valid = 0;
  pair_t         held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: frames are formed purely from the accepted sample order.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      frame_q.push_back(in_data);
      acc_count++;
      last_accept_cyc = cyc;
      if (frame_q.size() == N) begin
        for (int k = 0; k < HALF; k++) begin
          pair_t p;
          p.a    = frame_q[k];
          p.b    = frame_q[k + HALF];
          p.idx  = 3'(k);
          p.last = (k == HALF - 1);
          exp_q.push_back(p);
        end
        frame_q.delete();
      end
    end
  end

  // Monitor: compares every taken pair and checks stability while stalled.
  always @(negedge clk) begin
    pair_t cur;
    pair_t e;
    if (!rst_n) begin
      held_valid = 0;
    end else begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid) begin
        cur = {out_a, out_b, out_idx, out_last};
        if (held_valid) chk("stall_hold", 32'(cur), 32'(held));
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_pair");
          end else begin
            e = exp_q.pop_front();
            chk("pair", 32'(cur), 32'(e));
          end
          hs_cyc.push_back(cyc);
          held_valid = 0;
        end else begin
          held       = cur;
          held_valid = 1;
        end
      end else if (held_valid) begin
        fail("valid_dropped_while_stalled");
        held_valid = 0;
      end
      if (check_ready_high) chk("in_ready_high", 32'(in_ready), 32'd1);
    end
  end

  // Drives stim_q in order; inputs change #1 after a rising edge and the
  // handshake is judged from in_ready at the preceding falling edge.
  task automatic drive_all(input int gap, input bit rnd);
    bit acc;
    int wait_cnt;
    int g;
    while (stim_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = stim_q[0];
      wait_cnt = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        wait_cnt++;
        if (wait_cnt > 2000) break;
      end
      in_valid = 1'b0;
      if (!acc) begin
        fail("drive_timeout");
        stim_q.delete();
      end else begin
        void'(stim_q.pop_front());
        g = rnd ? int'($urandom_range(gap, 0)) : gap;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
  endtask

  // Asynchronous assert: outputs must reflect reset before any clock edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    frame_q.delete();
    exp_q.delete();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drv(input int max);
    int n = 0;
    while (!drv_done && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!drv_done) fail("driver_not_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1) One frame 1..16, unstalled.
    out_ready        = 1'b1;
    first_valid_cyc  = -1;
    check_ready_high = 1;
    for (int i = 1; i <= 16; i++) stim_q.push_back(8'(i));
    drive_all(0, 0);
    wait_drain(40);
    check_ready_high = 0;
    chk("first_valid_latency", 32'(first_valid_cyc), 32'(last_accept_cyc + 2));

    // 2) Continuous ramp 0x00..0xFF, 16 frames.
    hs_cyc.delete();
    check_ready_high = 1;
    for (int i = 0; i < 256; i++) stim_q.push_back(8'(i));
    drive_all(0, 0);
    wait_drain(60);
    check_ready_high = 0;
    chk("ramp_pair_count", 32'(hs_cyc.size()), 32'd128);
    if (hs_cyc.size() == 128) begin
      for (int f = 0; f < 16; f++) begin
        chk("ramp_frame_contiguous", 32'(hs_cyc[8*f+7] - hs_cyc[8*f]), 32'd7);
        if (f < 15) chk("ramp_frame_spacing", 32'(hs_cyc[8*f+8] - hs_cyc[8*f]), 32'd16);
      end
    end

    // 3) Stall from the first pair while 48 samples are offered.
    out_ready = 1'b0;
    acc_count = 0;
    for (int i = 1; i <= 48; i++) stim_q.push_back(8'(i));
    drv_done = 0;
    fork
      begin
        drive_all(0, 0);
        drv_done = 1;
      end
    join_none
    n = 0;
    while (acc_count < 32 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_accepted_32", 32'(acc_count), 32'd32);
    @(negedge clk);
    #1;
    chk("stall_in_ready_low", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("stall_accepted_still_32", 32'(acc_count), 32'd32);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_out_a", 32'(out_a), 32'd1);
    chk("stall_out_b", 32'(out_b), 32'd9);
    @(posedge clk);
    #1;
    hs_cyc.delete();
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_last && out_a == 8'd8 && out_b == 8'd16) && n < 50);
    chk("release_in_ready_before", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("release_in_ready_after", 32'(in_ready), 32'd1);
    wait_drv(100);
    wait_drain(60);
    chk("stall_total_pairs", 32'(hs_cyc.size()), 32'd24);
    if (hs_cyc.size() >= 16) chk("chain_no_bubble", 32'(hs_cyc[15] - hs_cyc[0]), 32'd15);

    // 4) out_ready toggling during a frame, random data.
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    drv_done = 0;
    fork
      begin
        drive_all(0, 0);
        drv_done = 1;
      end
    join_none
    n = 0;
    while ((!drv_done || exp_q.size() != 0 || out_valid) && n < 200) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    wait_drain(20);

    // 5a) Reset after sample 10 of a frame.
    for (int i = 0; i < 10; i++) stim_q.push_back(8'($urandom));
    drive_all(0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'hA0 + i));
    drive_all(0, 0);
    wait_drain(40);

    // 5b) Reset while pair 3 of a readout is presented.
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    drive_all(0, 0);
    n = 0;
    while (!(out_valid && out_idx == 3'd3) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pair3_reached", 32'(out_idx), 32'd3);
    do_reset();
    for (int i = 0; i < 16; i++) stim_q.push_back(8'(8'hA0 + i));
    drive_all(0, 0);
    wait_drain(40);

    // 6) Gapped input: 1 cycle on, 2 cycles off.
    first_valid_cyc = -1;
    for (int i = 0; i < 16; i++) stim_q.push_back(8'($urandom));
    drive_all(2, 0);
    wait_drain(40);
    chk("gapped_valid_latency", 32'(first_valid_cyc), 32'(last_accept_cyc + 2));

    // 7) Random gaps and random backpressure over several frames.
    for (int i = 0; i < 5 * N; i++) stim_q.push_back(8'($urandom));
    drv_done = 0;
    fork
      begin
        drive_all(3, 1);
        drv_done = 1;
      end
    join_none
    n = 0;
    while (!drv_done && n < 2000) begin
      out_ready = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      n++;
    end
    if (!drv_done) fail("random_driver_timeout");
    out_ready = 1'b1;
    wait_drain(100);
    chk("no_partial_frame", 32'(frame_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
